// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU datapath types. Provides the register-index and
//                data-word types used across the core, plus the scoreboard
//                entry record and its source-match helper used by the
//                forwarding scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    localparam int c_REG_W  = 5;    // 32 architectural registers
    localparam int c_WORD_W = 32;

    typedef logic [c_REG_W-1:0]  regbits_t;
    typedef logic [c_WORD_W-1:0] word_t;

    // One tracked in-flight instruction: only what forwarding needs to know.
    typedef struct packed {
        logic     valid;
        regbits_t rd;
        logic     wen;
        logic     load;
    } sb_entry_t;

    // An entry can supply a source operand only if it really writes that
    // register. Register 0 is hard-wired to zero and is never forwarded.
    function automatic logic entry_hits(sb_entry_t e, regbits_t r);
        return e.valid && e.wen && (r != '0) && (e.rd == r);
    endfunction

endpackage
`default_nettype wire

// File: rtl/forward_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : forward_scoreboard_if
//  Description : Bundle between the decode stage and the forwarding
//                scoreboard. Modport sb is the scoreboard's view.
//  Ports (sb)  : in  issue_valid, issue_rd, issue_wen, issue_load  decode slot
//                in  src[NSRC]           source registers being decoded
//                in  advance, flush      pipeline movement / squash
//                out fwd_sel[NSRC]       0 = register file, k = stage k
//                out stall               hold decode, insert a bubble
//                out stall_cnt           total stall cycles
//  Revision    : 1.0 - initial release
// ============================================================================
interface forward_scoreboard_if #(
    parameter int NSRC  = 2,
    parameter int DEPTH = 3,
    parameter int CNTW  = 16
);
    logic                                  issue_valid;
    cpu_types_pkg::regbits_t               issue_rd;
    logic                                  issue_wen;
    logic                                  issue_load;
    cpu_types_pkg::regbits_t [NSRC-1:0]    src;
    logic                                  advance;
    logic                                  flush;
    logic [NSRC-1:0][$clog2(DEPTH+1)-1:0]  fwd_sel;
    logic                                  stall;
    logic [CNTW-1:0]                       stall_cnt;

    modport sb (
        input  issue_valid,
        input  issue_rd,
        input  issue_wen,
        input  issue_load,
        input  src,
        input  advance,
        input  flush,
        output fwd_sel,
        output stall,
        output stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sb_match.sv
`default_nettype none
// ============================================================================
//  Module      : sb_match
//  Description : Per-source lookup into the scoreboard. Finds the youngest
//                in-flight producer of one source register and reports
//                whether that producer is a load whose data is not yet
//                available for forwarding.
//  Ports       : i_src          source register to look up
//                i_entries      all tracked stages, index 1 = youngest (EX)
//                o_fwd_sel      smallest matching stage, 0 when none match
//                o_load_hazard  youngest match is a load before LOAD_STAGE
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_match
    import cpu_types_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2
)(
    input  regbits_t                    i_src,
    input  sb_entry_t [DEPTH:1]         i_entries,
    output logic [$clog2(DEPTH+1)-1:0]  o_fwd_sel,
    output logic                        o_load_hazard
);

    localparam int c_SELW = $clog2(DEPTH+1);

    logic [c_SELW-1:0] w_sel;
    logic              w_hazard;

    // Scan from the oldest stage toward the youngest so that the last hit
    // written is the youngest producer. The hazard bit is taken from that
    // same entry only, so an older ALU result never masks a younger load.
    always_comb begin
        w_sel    = '0;
        w_hazard = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (entry_hits(i_entries[k], i_src)) begin
                w_sel    = c_SELW'(k);
                w_hazard = i_entries[k].load && (k < LOAD_STAGE);
            end
        end
    end

    assign o_fwd_sel     = w_sel;
    assign o_load_hazard = w_hazard;

endmodule
`default_nettype wire

// File: rtl/forward_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : forward_scoreboard
//  Description : Tracks the destination registers of instructions in the
//                EX..WB stages, selects the forwarding source for each
//                operand of the decoding instruction and raises a
//                load-use stall when a needed load result is not ready yet.
//  Ports       : CLK          clock, rising edge
//                nRST         asynchronous active-low reset
//                issue_valid  decode holds a real instruction
//                issue_rd     destination register
//                issue_wen    instruction writes issue_rd
//                issue_load   instruction is a load
//                src          NSRC source registers of the decoding instr
//                advance      pipeline moves this cycle
//                flush        squash all tracked entries
//                fwd_sel      per source: 0 = register file, k = stage k
//                stall        hold decode and insert a bubble
//                stall_cnt    saturating count of stall cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module forward_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int NSRC       = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int CNTW       = 16
)(
    input  logic                                  CLK,
    input  logic                                  nRST,
    input  logic                                  issue_valid,
    input  logic [c_REG_W-1:0]                    issue_rd,
    input  logic                                  issue_wen,
    input  logic                                  issue_load,
    input  logic [NSRC-1:0][c_REG_W-1:0]          src,
    input  logic                                  advance,
    input  logic                                  flush,
    output logic [NSRC-1:0][$clog2(DEPTH+1)-1:0]  fwd_sel,
    output logic                                  stall,
    output logic [CNTW-1:0]                       stall_cnt
);

    localparam int              c_SELW    = $clog2(DEPTH+1);
    localparam logic [CNTW-1:0] c_CNT_MAX = '1;

    sb_entry_t [DEPTH:1]          r_entries;
    logic [CNTW-1:0]              r_stall_cnt;

    logic [NSRC-1:0][c_SELW-1:0]  w_sel;
    logic [NSRC-1:0]              w_hazard;
    logic                         w_stall;
    sb_entry_t                    w_new_entry;

    // ------------------------------------------------------------------
    // Per-source lookup
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NSRC; i++) begin : g_src
            sb_match #(
                .DEPTH      (DEPTH),
                .LOAD_STAGE (LOAD_STAGE)
            ) u_match (
                .i_src         (src[i]),
                .i_entries     (r_entries),
                .o_fwd_sel     (w_sel[i]),
                .o_load_hazard (w_hazard[i])
            );
        end
    endgenerate

    // A bubble in decode has no operands, so it can never stall.
    assign w_stall = issue_valid && (|w_hazard);

    // The entries are already cleared during reset, so these gates are
    // redundant in normal operation; they make the reset-time output values
    // independent of anything that might still be on the inputs.
    assign stall   = nRST & w_stall;
    assign fwd_sel = nRST ? w_sel : '0;

    // ------------------------------------------------------------------
    // Entry presented to stage 1: a stalled instruction stays in decode
    // and a bubble goes down the pipe instead.
    // ------------------------------------------------------------------
    always_comb begin
        w_new_entry = '0;
        if (issue_valid && !w_stall) begin
            w_new_entry.valid = 1'b1;
            w_new_entry.rd    = issue_rd;
            w_new_entry.wen   = issue_wen;
            w_new_entry.load  = issue_load;
        end
    end

    // ------------------------------------------------------------------
    // Stage tracking: flush wins over advance; without advance all hold.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_entries <= '0;
        end else if (flush) begin
            r_entries <= '0;
        end else if (advance) begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_entries[k] <= r_entries[k-1];
            end
            r_entries[1] <= w_new_entry;
        end
    end

    // ------------------------------------------------------------------
    // Stall cycle counter. A stall only costs a cycle when the pipe would
    // otherwise have moved, hence the qualification with advance.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
        end else if (w_stall && advance && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_forward_scoreboard.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_forward_scoreboard
//  Description : Self-checking bench for forward_scoreboard. Two instances
//                share all inputs: the default 16-bit counter and a 2-bit
//                counter to exercise saturation. Expected outputs come from
//                a queue-based pipeline model and are checked by a separate
//                monitor each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_scoreboard;

    localparam int c_NSRC       = 2;
    localparam int c_DEPTH      = 3;
    localparam int c_LOAD_STAGE = 2;
    localparam int c_CNTW       = 16;
    localparam int c_CNTW_S     = 2;
    localparam int c_SELW       = $clog2(c_DEPTH+1);
    localparam int c_MAX        = (1 << c_CNTW) - 1;
    localparam int c_MAX_S      = (1 << c_CNTW_S) - 1;

    logic                             CLK = 1'b0;
    logic                             nRST = 1'b0;
    logic                             issue_valid = 1'b0;
    logic [4:0]                       issue_rd = '0;
    logic                             issue_wen = 1'b0;
    logic                             issue_load = 1'b0;
    logic [c_NSRC-1:0][4:0]           src = '0;
    logic                             advance = 1'b0;
    logic                             flush = 1'b0;
    logic [c_NSRC-1:0][c_SELW-1:0]    fwd_sel;
    logic                             stall;
    logic [c_CNTW-1:0]                stall_cnt;
    logic [c_NSRC-1:0][c_SELW-1:0]    fwd_sel_s;
    logic                             stall_s;
    logic [c_CNTW_S-1:0]              stall_cnt_s;

    always #5 CLK = ~CLK;

    forward_scoreboard #(
        .NSRC(c_NSRC), .DEPTH(c_DEPTH), .LOAD_STAGE(c_LOAD_STAGE), .CNTW(c_CNTW)
    ) u_dut (
        .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_wen(issue_wen), .issue_load(issue_load), .src(src),
        .advance(advance), .flush(flush), .fwd_sel(fwd_sel), .stall(stall),
        .stall_cnt(stall_cnt)
    );

    forward_scoreboard #(
        .NSRC(c_NSRC), .DEPTH(c_DEPTH), .LOAD_STAGE(c_LOAD_STAGE), .CNTW(c_CNTW_S)
    ) u_dut_s (
        .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_wen(issue_wen), .issue_load(issue_load), .src(src),
        .advance(advance), .flush(flush), .fwd_sel(fwd_sel_s), .stall(stall_s),
        .stall_cnt(stall_cnt_s)
    );

    // ------------------------------------------------------------------
    // Reference model: pipe[0] is the instruction in EX, pipe[1] in MEM...
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wen;
        logic       ld;
    } instr_t;

    typedef struct packed {
        logic [c_NSRC-1:0][c_SELW-1:0] sel;
        logic                          stall;
        logic [31:0]                   cnt;
        logic [31:0]                   cnt_s;
    } exp_t;

    instr_t pipe[$];
    exp_t   exp_q[$];
    int     m_cnt;
    int     m_cnt_s;
    logic   m_stall;
    int     n_checks = 0;
    int     n_errors = 0;

    function automatic void chk(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_clear();
        pipe.delete();
        for (int k = 0; k < c_DEPTH; k++) pipe.push_back('0);
    endfunction

    // Youngest in-flight writer of register s, as a 1-based stage number.
    function automatic int model_sel(int s);
        if (s == 0) return 0;
        for (int k = 0; k < pipe.size(); k++) begin
            if (pipe[k].v && pipe[k].wen && (int'(pipe[k].rd) == s)) return k + 1;
        end
        return 0;
    endfunction

    // Drive one cycle of decode inputs and queue what the outputs must be.
    task automatic set_in(input logic v, input int rd, input logic wen, input logic ld,
                          input int s0, input int s1, input logic adv, input logic fl);
        exp_t e;
        int   sel;
        issue_valid = v;
        issue_rd    = 5'(rd);
        issue_wen   = wen;
        issue_load  = ld;
        src[0]      = 5'(s0);
        src[1]      = 5'(s1);
        advance     = adv;
        flush       = fl;
        e = '0;
        for (int i = 0; i < c_NSRC; i++) begin
            sel = model_sel(int'(src[i]));
            e.sel[i] = c_SELW'(sel);
            if (v && sel != 0 && sel < c_LOAD_STAGE && pipe[sel-1].ld) e.stall = 1'b1;
        end
        e.cnt   = 32'(m_cnt);
        e.cnt_s = 32'(m_cnt_s);
        m_stall = e.stall;
        exp_q.push_back(e);
    endtask

    // Wait for the clock edge and apply its effect to the model.
    task automatic tick();
        instr_t n;
        @(posedge CLK);
        if (nRST) begin
            if (m_stall && advance) begin
                if (m_cnt < c_MAX) m_cnt++;
                if (m_cnt_s < c_MAX_S) m_cnt_s++;
            end
            if (flush) begin
                model_clear();
            end else if (advance) begin
                n = '0;
                if (issue_valid && !m_stall) begin
                    n.v = 1'b1; n.rd = issue_rd; n.wen = issue_wen; n.ld = issue_load;
                end
                pipe.push_front(n);
                void'(pipe.pop_back());
            end
        end
        #1;
    endtask

    // Reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        nRST = 1'b0;
        #1;
        for (int i = 0; i < c_NSRC; i++) chk("rst_fwd_sel", int'(fwd_sel[i]), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_stall_cnt_s", int'(stall_cnt_s), 0);
        issue_valid = 1'b0; issue_rd = '0; issue_wen = 1'b0; issue_load = 1'b0;
        src = '0; advance = 1'b0; flush = 1'b0;
        model_clear();
        m_cnt = 0; m_cnt_s = 0; m_stall = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Monitor: outputs are combinational, compare mid-cycle.
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < c_NSRC; i++) begin
                    chk("fwd_sel", int'(fwd_sel[i]), int'(e.sel[i]));
                    chk("fwd_sel_s", int'(fwd_sel_s[i]), int'(e.sel[i]));
                end
                chk("stall", int'(stall), int'(e.stall));
                chk("stall_s", int'(stall_s), int'(e.stall));
                chk("stall_cnt", int'(stall_cnt), int'(e.cnt));
                chk("stall_cnt_s", int'(stall_cnt_s), int'(e.cnt_s));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        model_clear();
        m_cnt = 0; m_cnt_s = 0; m_stall = 1'b0;
        @(posedge CLK);
        #1;
        do_reset();

        // ALU rd=5 forwarded from EX, then from MEM
        set_in(1, 5, 1, 0, 0, 0, 1, 0); tick();
        set_in(0, 0, 0, 0, 5, 0, 1, 0); #1;
        chk("alu_ex_sel", int'(fwd_sel[0]), 1);
        chk("alu_ex_stall", int'(stall), 0);
        tick();
        set_in(0, 0, 0, 0, 5, 0, 1, 0); #1;
        chk("alu_mem_sel", int'(fwd_sel[0]), 2);
        tick();

        // Load-use: one stall cycle then forward from MEM
        do_reset();
        set_in(1, 8, 1, 1, 0, 0, 1, 0); tick();
        set_in(1, 1, 1, 0, 0, 8, 1, 0); #1;
        chk("ld_use_stall", int'(stall), 1);
        chk("ld_use_cnt0", int'(stall_cnt), 0);
        tick();
        set_in(1, 1, 1, 0, 0, 8, 1, 0); #1;
        chk("ld_use_release", int'(stall), 0);
        chk("ld_use_sel", int'(fwd_sel[1]), 2);
        chk("ld_use_cnt1", int'(stall_cnt), 1);
        tick();

        // Youngest producer wins
        set_in(1, 3, 1, 0, 0, 0, 1, 0); tick();
        set_in(1, 3, 1, 0, 0, 0, 1, 0); tick();
        set_in(0, 0, 0, 0, 3, 0, 1, 0); #1;
        chk("youngest_sel", int'(fwd_sel[0]), 1);
        tick();

        // Register 0 never matches
        set_in(1, 0, 1, 0, 0, 0, 1, 0); tick();
        set_in(1, 4, 1, 0, 0, 0, 1, 0); #1;
        chk("r0_sel", int'(fwd_sel[0]), 0);
        chk("r0_stall", int'(stall), 0);
        tick();

        // Flush discards a pending load
        set_in(1, 9, 1, 1, 0, 0, 1, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 1); tick();
        set_in(1, 2, 1, 0, 9, 0, 1, 0); #1;
        chk("flush_sel", int'(fwd_sel[0]), 0);
        chk("flush_stall", int'(stall), 0);
        tick();

        // Five forced stalls: 2-bit counter saturates at 3
        do_reset();
        for (int n = 0; n < 5; n++) begin
            set_in(1, 10, 1, 1, 0, 0, 1, 0); tick();
            set_in(1, 10, 1, 1, 10, 0, 1, 0); #1;
            chk("forced_stall", int'(stall), 1);
            tick();
        end
        chk("sat_cnt16", int'(stall_cnt), 5);
        chk("sat_cnt2", int'(stall_cnt_s), 3);

        // Reset with three valid entries and a live stall
        set_in(1, 1, 1, 0, 0, 0, 1, 0); tick();
        set_in(1, 2, 1, 0, 0, 0, 1, 0); tick();
        set_in(1, 3, 1, 1, 0, 0, 1, 0); tick();
        src[0] = 5'd3;
        src[1] = 5'd1;
        #1;
        chk("pre_rst_stall", int'(stall), 1);
        chk("pre_rst_sel0", int'(fwd_sel[0]), 1);
        chk("pre_rst_sel1", int'(fwd_sel[1]), 3);
        do_reset();

        // Randomized traffic with occasional asynchronous resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                set_in(logic'($urandom_range(0, 3) != 0),
                       int'($urandom_range(0, 7)),
                       logic'($urandom_range(0, 4) != 0),
                       logic'($urandom_range(0, 2) == 0),
                       int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)),
                       logic'($urandom_range(0, 6) != 0),
                       logic'($urandom_range(0, 24) == 0));
                tick();
            end
        end

        for (int w = 0; w < 4 && exp_q.size() != 0; w++) @(negedge CLK);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001: The block SHALL have parameter NSRC, default 2, meaning the number of source operands checked per issued instruction.
REQ-002: The block SHALL have parameter DEPTH, default 3, meaning the number of tracked in-flight stages (1=EX, 2=MEM, 3=WB).
REQ-003: The block SHALL have parameter LOAD_STAGE, default 2, meaning the first stage whose result is forwardable for a load.
REQ-004: The block SHALL have parameter CNTW, default 16, meaning the stall counter width.
REQ-005: The block SHALL have ports: CLK  in  1  clock, rising edge; nRST  in  1  asynchronous active-low reset.
REQ-006: The block SHALL have ports: issue_valid  in  1  decode stage holds a real instruction; issue_rd  in  regbits_t  destination register; issue_wen  in  1  instruction writes issue_rd; issue_load  in  1  instruction is a load.
REQ-007: The block SHALL have ports: src  in  NSRC x regbits_t  source registers of the decoding instruction; advance  in  1  pipeline moves this cycle; flush  in  1  squash all tracked entries.
REQ-008: The block SHALL have ports: fwd_sel  out  NSRC x $clog2(DEPTH+1)  per-source select (0=register file, k=stage k); stall  out  1  hold decode and insert bubble; stall_cnt  out  CNTW  total stall cycles.

Function
REQ-009: The block SHALL hold DEPTH entries {valid, rd, wen, load}; entry k models stage k.
REQ-010: On a rising CLK with advance=1 and flush=0, entry k SHALL take entry k-1 for k>=2, and entry 1 SHALL take the issue fields if issue_valid=1 and stall=0, else a bubble (valid=0).
REQ-011: With advance=0 and flush=0, all entries SHALL hold.
REQ-012: flush=1 SHALL clear valid in every entry on the next edge and SHALL take priority over advance.
REQ-013: Entry k SHALL match source i when valid=1, wen=1, rd=src[i] and src[i]!=0; register 0 SHALL never match.
REQ-014: fwd_sel[i] SHALL be combinational, equal to the smallest matching k (youngest producer wins), or 0 when no entry matches.
REQ-015: stall SHALL be combinational, asserted when issue_valid=1 and, for some i, the youngest match for src[i] is a load at stage k<LOAD_STAGE.
REQ-016: Stall SHALL depend only on the youngest match; an older non-load match at a larger k SHALL not clear it.
REQ-017: stall_cnt SHALL increment by 1 on each edge where stall=1 and advance=1, and SHALL saturate at 2^CNTW-1.
REQ-018: A stalled instruction SHALL be re-evaluated each cycle and SHALL issue on the first cycle in which stall is 0 and advance is 1.
REQ-019: Latency SHALL be zero cycles from src to fwd_sel/stall, and one edge from issue to entry 1.

Reset
REQ-020: nRST=0 SHALL asynchronously clear every entry valid, wen and load bit and clear stall_cnt to 0.
REQ-021: While nRST=0, fwd_sel SHALL read 0 and stall SHALL read 0.
REQ-022: Reset asserted mid-stall SHALL discard the stall with no counter increment on that edge.

Structure
REQ-023: regbits_t and word_t SHALL come from cpu_types_pkg.
REQ-024: A new package typedef sb_entry_t {valid, rd, wen, load} SHALL be added to cpu_types_pkg.
REQ-025: The interface SHALL be forward_scoreboard_if with modport sb, using the same naming scheme as forward_unit_if.
REQ-026: One sub-module, sb_match, SHALL be used: it takes one src and all entries and produces that source's fwd_sel and load-hazard bit; it SHALL be instantiated NSRC times.

Verification
REQ-027: Issue an ALU op with rd=5, advance=1, then next cycle src[0]=5 -> fwd_sel[0]=1 and stall=0; one cycle later with advance=1 -> fwd_sel[0]=2.
REQ-028: Issue a load with rd=8, then src[1]=8 -> stall=1 for exactly one cycle and stall_cnt goes 0->1, then fwd_sel[1]=2 and stall=0.
REQ-029: Issue ALU rd=3, then ALU rd=3, then src[0]=3 -> fwd_sel[0]=1, i.e. the youngest producer wins over stage 2.
REQ-030: Issue rd=0 with wen=1, then src[0]=0 -> fwd_sel[0]=0 and stall=0.
REQ-031: Issue a load rd=9, then flush=1 with advance=1, then src[0]=9 -> fwd_sel[0]=0 and stall=0; with CNTW=2 and 5 forced stall cycles -> stall_cnt=3.
REQ-032: Assert nRST=0 mid-pipeline with 3 valid entries -> all fwd_sel=0, stall=0 and stall_cnt=0 immediately, without waiting for a clock edge.
